matrix_mult_unit: RTL and testbench

Bus-attached execution unit that multiplies two signed 16-bit 4x4 matrices, full matrix product or element-wise product, over a fixed 16-cycle sequence. It sits beside the integer and matrix ALUs, directly downstream of the execution state machine. It captures operands and opcode from the execution engine's 256-bit output bus and returns its result through the data mux on engine reads. The unit runs multi-cycle, so it provides a status register that the execution engine polls before reading the result.

---
 rtl/matrix_pkg.sv | 27 ++
 rtl/mat_dot4.sv | 15 +
 rtl/matrix_mult_unit.sv | 96 +++++++++
 tb/tb_matrix_mult_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types, register map and element conversion for matrix_mult_unit.
// Define MATMUL_SATURATE_EN to clamp result elements instead of wrapping them.
package matrix_pkg;
   localparam logic [3:0] UNIT_ID = 4'h5;
   localparam logic [3:0] REG_SRC1 = 4'd0;
   localparam logic [3:0] REG_SRC2 = 4'd1;
   localparam logic [3:0] REG_OPCODE = 4'd2;
   localparam logic [3:0] REG_RESULT = 4'd3;
   localparam logic [3:0] REG_STATUS = 4'd4;
   // [r][c] lands on bits 16*(4r+c) of the bus, so packing is a plain cast
   typedef logic signed [3:0][3:0][15:0] mat4x4_t;
   typedef enum logic [3:0] {OP_MMULT = 4'd1, OP_HADAMARD = 4'd2} opcode_t;
   typedef enum logic {IDLE, COMPUTE} state_t;
   function automatic mat4x4_t unpackMat(input logic [255:0] bus);
      return mat4x4_t'(bus);
   endfunction
   function automatic logic [255:0] packMat(input mat4x4_t m);
      return 256'(m);
   endfunction
   function automatic logic [15:0] toElem(input logic signed [33:0] v);
`ifdef MATMUL_SATURATE_EN
      return v > 34'sd32767 ? 16'h7fff : v < -34'sd32768 ? 16'h8000 : v[15:0];
`else
      return v[15:0];
`endif
   endfunction
endpackage

// File: rtl/mat_dot4.sv
// mat_dot4: combinational signed 4-term dot product of 16-bit elements, 34-bit result.
module mat_dot4 (
   input  logic [3:0][15:0]    a,
   input  logic [3:0][15:0]    b,
   output logic signed [33:0]  dot
);
   logic signed [31:0] prod [4];
   always_comb begin
      dot = '0;
      for (int k = 0; k < 4; k++) begin
         prod[k] = 32'($signed(a[k])) * 32'($signed(b[k]));
         dot = dot + 34'(prod[k]);
      end
   end
endmodule

// File: rtl/matrix_mult_unit.sv
// matrix_mult_unit: bus-attached 4x4 signed matrix multiply / Hadamard unit, one element per cycle.
// Define MATMUL_SATURATE_EN to clamp result elements instead of wrapping them.
module matrix_mult_unit
   import matrix_pkg::*;
(
   input  logic          Clk,
   input  logic          nReset,
   output logic [255:0]  DataOut,
   input  logic [255:0]  DataIn,
   input  logic [15:0]   address,
   input  logic          nRead,
   input  logic          nWrite,
   input  logic          src1onBus,
   input  logic          src2onBus,
   input  logic          opcodeonBus,
   input  logic          destonBus
);
   state_t state, stateNext;
   mat4x4_t srcA, srcB, work, workNext, result;
   logic [3:0] opcode, e, offset;
   logic [1:0] row, col;
   logic done, err, busy, sel, wrEn, wrOp, opValid, rdResult;
   logic [3:0][15:0] dotA, dotB;
   logic signed [33:0] dot;
   logic unusedAddr;

   assign unusedAddr = ^address[11:4];
   assign offset = address[3:0];
   assign sel = address[15:12] == UNIT_ID;
   assign busy = state == COMPUTE;
   assign wrEn = sel && !nWrite && !busy;
   assign wrOp = wrEn && offset == REG_OPCODE && opcodeonBus;
   assign opValid = DataIn[3:0] == OP_MMULT || DataIn[3:0] == OP_HADAMARD;
   assign rdResult = sel && !nRead && offset == REG_RESULT && destonBus;
   assign row = e[3:2];
   assign col = e[1:0];

   // Hadamard uses only term 0; the other three are forced to zero
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         dotA[k] = opcode == OP_MMULT ? srcA[row][2'(k)] : k == 0 ? srcA[row][col] : '0;
         dotB[k] = opcode == OP_MMULT ? srcB[2'(k)][col] : k == 0 ? srcB[row][col] : '0;
      end
   end

   mat_dot4 dotUnit (.a(dotA), .b(dotB), .dot(dot));

   always_comb begin
      workNext = work;
      workNext[row][col] = toElem(dot);
   end

   always_comb stateNext = state == IDLE ? (wrOp && opValid ? COMPUTE : IDLE) : (e == 4'd15 ? IDLE : COMPUTE);

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) state <= IDLE;
      else state <= stateNext;
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         srcA <= '0;
         srcB <= '0;
         work <= '0;
         result <= '0;
         opcode <= '0;
         e <= '0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         if (wrEn && offset == REG_SRC1 && src1onBus) srcA <= unpackMat(DataIn);
         if (wrEn && offset == REG_SRC2 && src2onBus) srcB <= unpackMat(DataIn);
         if (wrOp) begin
            opcode <= DataIn[3:0];
            done <= !opValid;
            err <= !opValid;
            e <= '0;
         end else if (rdResult && !busy) done <= 1'b0;
         if (busy) begin
            work <= workNext;
            e <= e + 4'd1;
            if (e == 4'd15) begin
               result <= workNext;
               done <= 1'b1;
            end
         end
      end
   end

   assign DataOut = !(sel && !nRead) ? '0 :
                    offset == REG_SRC1 ? packMat(srcA) :
                    offset == REG_SRC2 ? packMat(srcB) :
                    offset == REG_OPCODE ? {252'b0, opcode} :
                    offset == REG_RESULT && destonBus ? packMat(result) :
                    offset == REG_STATUS ? {253'b0, err, done, busy} : '0;
endmodule

// File: tb/tb_matrix_mult_unit.sv
// tb_matrix_mult_unit: directed self-checking bench for matrix_mult_unit.
module tb_matrix_mult_unit;
   localparam logic [3:0] UNIT = 4'h5;
   logic Clk = 1'b0;
   logic nReset = 1'b0;
   logic [255:0] DataOut, DataIn = '0;
   logic [15:0] address = '0;
   logic nRead = 1'b1, nWrite = 1'b1;
   logic src1onBus = 1'b0, src2onBus = 1'b0, opcodeonBus = 1'b0, destonBus = 1'b0;
   int checks = 0;
   int fails = 0;
   logic [255:0] rd;
   logic [255:0] ident, seq, fill2, fill3, fill18, fillBig, fillOvf, fillNeg1, hadExp;

   always #5 Clk = ~Clk;

   matrix_mult_unit dut (
      .Clk(Clk), .nReset(nReset), .DataOut(DataOut), .DataIn(DataIn), .address(address),
      .nRead(nRead), .nWrite(nWrite), .src1onBus(src1onBus), .src2onBus(src2onBus),
      .opcodeonBus(opcodeonBus), .destonBus(destonBus)
   );

   function automatic logic [255:0] fillMat(input logic [15:0] v);
      logic [255:0] m;
      for (int i = 0; i < 16; i++) m[16*i +: 16] = v;
      return m;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic busWrite(input logic [3:0] off, input logic [255:0] d);
      @(negedge Clk);
      address = {UNIT, 8'h00, off};
      DataIn = d;
      nWrite = 1'b0;
      src1onBus = off == 4'd0;
      src2onBus = off == 4'd1;
      opcodeonBus = off == 4'd2;
      destonBus = off == 4'd3;
      @(posedge Clk);
      #1;
      nWrite = 1'b1;
      {src1onBus, src2onBus, opcodeonBus, destonBus} = '0;
   endtask

   task automatic busRead(input logic [3:0] unit, input logic [3:0] off, input logic dest, output logic [255:0] d);
      @(negedge Clk);
      address = {unit, 8'h00, off};
      nRead = 1'b0;
      destonBus = dest;
      #1 d = DataOut;
      @(posedge Clk);
      #1;
      nRead = 1'b1;
      destonBus = 1'b0;
   endtask

   task automatic expectReg(input string tag, input logic [3:0] off, input logic [255:0] exp);
      logic [255:0] d;
      busRead(UNIT, off, off == 4'd3, d);
      check(tag, d, exp);
   endtask

   // opcode captured at edge T; busy through edge T+15, done at T+16
   task automatic runOp(input string tag, input logic [3:0] op, input logic [255:0] exp);
      busWrite(4'd2, {252'b0, op});
      expectReg({tag, "_busy_start"}, 4'd4, 256'h1);
      repeat (14) @(posedge Clk);
      expectReg({tag, "_busy_last"}, 4'd4, 256'h1);
      expectReg({tag, "_done"}, 4'd4, 256'h2);
      expectReg({tag, "_result"}, 4'd3, exp);
      expectReg({tag, "_done_cleared"}, 4'd4, 256'h0);
   endtask

   initial begin
      ident = '0;
      for (int r = 0; r < 4; r++) ident[16*(5*r) +: 16] = 16'h0001;
      for (int i = 0; i < 16; i++) seq[16*i +: 16] = 16'(i + 1);
      for (int i = 0; i < 16; i++) hadExp[16*i +: 16] = 16'hffff - 16'(i);
      fill2 = fillMat(16'h0002);
      fill3 = fillMat(16'h0003);
      fill18 = fillMat(16'h0018);
      fillBig = fillMat(16'h4000);
      fillNeg1 = fillMat(16'hffff);
`ifdef MATMUL_SATURATE_EN
      fillOvf = fillMat(16'h7fff);
`else
      fillOvf = fillMat(16'h0000);
`endif
      repeat (3) @(negedge Clk);
      nReset = 1'b1;
      expectReg("reset_status", 4'd4, 256'h0);
      expectReg("reset_result", 4'd3, 256'h0);
      expectReg("reset_opcode", 4'd2, 256'h0);

      busWrite(4'd0, ident);
      busWrite(4'd1, seq);
      expectReg("src1_readback", 4'd0, ident);
      expectReg("src2_readback", 4'd1, seq);
      runOp("ident_mmult", 4'd1, seq);

      busWrite(4'd0, fill2);
      busWrite(4'd1, fill3);
      runOp("fill_mmult", 4'd1, fill18);

      busWrite(4'd0, fillBig);
      busWrite(4'd1, fillMat(16'h0004));
      runOp("overflow_mmult", 4'd1, fillOvf);

      busWrite(4'd0, seq);
      busWrite(4'd1, fillNeg1);
      runOp("hadamard", 4'd2, hadExp);

      busWrite(4'd0, fill2);
      busWrite(4'd1, fill3);
      busWrite(4'd2, 256'h1);
      repeat (8) @(posedge Clk);
      #2 nReset = 1'b0;
      #1;
      address = {UNIT, 8'h00, 4'd4};
      nRead = 1'b0;
      #1 check("midop_reset_status", DataOut, 256'h0);
      address = {UNIT, 8'h00, 4'd3};
      destonBus = 1'b1;
      #1 check("midop_reset_result", DataOut, 256'h0);
      nRead = 1'b1;
      destonBus = 1'b0;
      @(negedge Clk);
      nReset = 1'b1;
      busWrite(4'd0, ident);
      busWrite(4'd1, seq);
      runOp("after_reset", 4'd1, seq);

      busWrite(4'd2, 256'h7);
      expectReg("badop_status", 4'd4, 256'h6);
      expectReg("badop_result", 4'd3, seq);
      expectReg("badop_done_cleared", 4'd4, 256'h4);

      busWrite(4'd1, fill3);
      busWrite(4'd2, 256'h1);
      busWrite(4'd0, fill2);
      expectReg("busy_result_read", 4'd3, seq);
      repeat (13) @(posedge Clk);
      expectReg("busy_write_busy", 4'd4, 256'h1);
      expectReg("busy_write_done", 4'd4, 256'h2);
      expectReg("busy_write_result", 4'd3, fill3);
      expectReg("busy_write_src1", 4'd0, ident);

      busRead(4'h3, 4'd4, 1'b0, rd);
      check("unselected_read", rd, 256'h0);
      busRead(UNIT, 4'd3, 1'b0, rd);
      check("result_no_dest", rd, 256'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
